// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owner of the register file's single write port.
// After reset (or on a clear request) it sweeps zeros into x1..x(NREG-1).
// It then shares the port between two writeback requesters using
// round-robin arbitration. Writes to x0 are accepted but never issued.
module regfile_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_req,
   input  logic                     req0_valid,
   input  logic [$clog2(NREG)-1:0]  req0_rd,
   input  logic [XLEN-1:0]          req0_data,
   output logic                     req0_ready,
   input  logic                     req1_valid,
   input  logic [$clog2(NREG)-1:0]  req1_rd,
   input  logic [XLEN-1:0]          req1_data,
   output logic                     req1_ready,
   output logic [$clog2(NREG)-1:0]  A3,
   output logic [XLEN-1:0]          WD3,
   output logic                     WE3,
   output logic                     busy,
   output logic                     last_gnt
);

   localparam int AW = $clog2(NREG);
   localparam logic [AW-1:0] LAST_REG  = AW'(NREG - 1);
   localparam logic [AW-1:0] FIRST_REG = AW'(1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_ARB   = 1'b1
   } state_t;

   state_t          r_state, w_state_next;
   logic [AW-1:0]   r_cnt, w_cnt_next;
   logic            r_last_gnt, w_last_gnt_next;
   logic [AW-1:0]   r_a3, w_a3_next;
   logic [XLEN-1:0] r_wd3, w_wd3_next;
   logic            r_we3, w_we3_next;

   logic [1:0]      w_valid;
   logic [1:0]      w_ready;
   logic [1:0]      w_acc;
   logic            w_arb_open;
   logic            w_acc_any;
   logic            w_sel;
   logic [AW-1:0]   w_sel_rd;
   logic [XLEN-1:0] w_sel_data;

   assign w_valid    = {req1_valid, req0_valid};

   // A clear request takes priority over any writeback in the same cycle.
   assign w_arb_open = (r_state == ST_ARB) && !clr_req;

   // Each port's ready looks only at the other port's valid, never its own,
   // so a requester may derive valid from ready without forming a loop.
   // When both are valid the port that did not win last time goes first.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         assign w_ready[gi] = w_arb_open &&
                              (!w_valid[1-gi] || (r_last_gnt != 1'(gi)));
         assign w_acc[gi]   = w_valid[gi] && w_ready[gi];
      end
   endgenerate

   // At most one port can be accepted per cycle; pick its payload.
   assign w_acc_any  = |w_acc;
   assign w_sel      = w_acc[1];
   assign w_sel_rd   = w_sel ? req1_rd   : req0_rd;
   assign w_sel_data = w_sel ? req1_data : req0_data;

   // Next-state and write-port logic for the clear sweep and arbitration.
   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_last_gnt_next = r_last_gnt;
      w_a3_next       = r_a3;
      w_wd3_next      = r_wd3;
      w_we3_next      = 1'b0;

      case (r_state)
         ST_CLEAR: begin
            // One zero write per cycle; the counter stops at the last
            // register so it never wraps back onto x0.
            w_we3_next = 1'b1;
            w_a3_next  = r_cnt;
            w_wd3_next = '0;
            if (r_cnt == LAST_REG) begin
               w_state_next = ST_ARB;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_ARB: begin
            if (clr_req) begin
               w_state_next = ST_CLEAR;
               w_cnt_next   = FIRST_REG;
            end else if (w_acc_any) begin
               // An x0 write is consumed here but leaves the enable low.
               w_a3_next       = w_sel_rd;
               w_wd3_next      = w_sel_data;
               w_we3_next      = (w_sel_rd != '0);
               w_last_gnt_next = w_sel;
            end
         end
      endcase
   end

   // State register; reset squashes any in-flight write and restarts the sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_cnt      <= FIRST_REG;
         r_last_gnt <= 1'b1;
         r_a3       <= '0;
         r_wd3      <= '0;
         r_we3      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_last_gnt <= w_last_gnt_next;
         r_a3       <= w_a3_next;
         r_wd3      <= w_wd3_next;
         r_we3      <= w_we3_next;
      end
   end

   assign req0_ready = w_ready[0];
   assign req1_ready = w_ready[1];
   assign A3         = r_a3;
   assign WD3        = r_wd3;
   assign WE3        = r_we3;
   assign busy       = (r_state == ST_CLEAR);
   assign last_gnt   = r_last_gnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the register-file write-port
// controller, with a behavioural register file hanging off A3/WD3/WE3.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_req;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_rd, req1_rd;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic [4:0]  A3;
   logic [31:0] WD3;
   logic        WE3;
   logic        busy;
   logic        last_gnt;

   int          n_checks = 0;
   int          n_errors = 0;

   // Expected register-file writes, {address, data}, in issue order.
   logic [36:0] exp_q[$];
   logic [36:0] mon_e;

   // Behavioural register file; x1..x31 start non-zero so the sweep is visible.
   logic [31:0] rf [32];
   logic        rf_loaded = 1'b0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr_req    (clr_req),
      .req0_valid (req0_valid),
      .req0_rd    (req0_rd),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_rd    (req1_rd),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .A3         (A3),
      .WD3        (WD3),
      .WE3        (WE3),
      .busy       (busy),
      .last_gnt   (last_gnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Register file commits on the edge at the end of a WE3 cycle.
   always @(posedge clk) begin
      if (!rf_loaded) begin
         rf[0] <= 32'd0;
         for (int i = 1; i < 32; i++) rf[i] <= 32'hBAD0_0000 | 32'(i);
         rf_loaded <= 1'b1;
      end else if (WE3 === 1'b1) begin
         rf[A3] <= WD3;
      end
   end

   // Every issued write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (WE3 === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("we_unexpected", {63'd0, WE3}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_a3", {59'd0, A3}, {59'd0, mon_e[36:32]});
            chk("wr_wd3", {32'd0, WD3}, {32'd0, mon_e[31:0]});
            $display("write x%0d <= %08h", A3, WD3);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_sweep(input int last);
      for (int i = 1; i <= last; i++) exp_q.push_back({5'(i), 32'd0});
   endtask

   // Run the 31 sweep edges; busy and readiness change only after the last one.
   task automatic do_sweep();
      for (int i = 1; i <= 31; i++) begin
         tick();
         chk("sweep_we", {63'd0, WE3}, 64'd1);
         chk("sweep_busy", {63'd0, busy}, {63'd0, (i < 31)});
         chk("sweep_rdy0", {63'd0, req0_ready}, {63'd0, (i == 31)});
      end
   endtask

   initial begin
      rst = 1'b1; clr_req = 1'b0;
      req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
      req1_valid = 1'b0; req1_rd = '0; req1_data = '0;

      // Reset state
      tick(); tick();
      chk("rst_a3", {59'd0, A3}, 64'd0);
      chk("rst_wd3", {32'd0, WD3}, 64'd0);
      chk("rst_we3", {63'd0, WE3}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd1);
      chk("rst_rdy0", {63'd0, req0_ready}, 64'd0);
      chk("rst_rdy1", {63'd0, req1_ready}, 64'd0);
      chk("rst_last_gnt", {63'd0, last_gnt}, 64'd1);

      // Power-on sweep
      push_sweep(31);
      rst = 1'b0;
      do_sweep();
      tick();
      for (int i = 1; i < 32; i++) chk("swept_reg", {32'd0, rf[i]}, 64'd0);

      // Both ports valid: grants alternate starting with port 0
      req0_valid = 1'b1; req0_rd = 5'd2; req0_data = 32'h1234_5678;
      req1_valid = 1'b1; req1_rd = 5'd3; req1_data = 32'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("alt_rdy0", {63'd0, req0_ready}, {63'd0, (k % 2 == 0)});
         chk("alt_rdy1", {63'd0, req1_ready}, {63'd0, (k % 2 == 1)});
         if (k % 2 == 0) exp_q.push_back({5'd2, 32'h1234_5678});
         else            exp_q.push_back({5'd3, 32'hDEAD_BEEF});
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("alt_last_gnt", {63'd0, last_gnt}, 64'd1);
      tick();
      chk("alt_x2", {32'd0, rf[2]}, 64'h1234_5678);
      chk("alt_x3", {32'd0, rf[3]}, 64'hDEAD_BEEF);

      // Port 0 alone writes x1
      req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'hAAAA_BBBB;
      #1;
      chk("p0_rdy", {63'd0, req0_ready}, 64'd1);
      exp_q.push_back({5'd1, 32'hAAAA_BBBB});
      tick();
      req0_valid = 1'b0;
      chk("p0_we3", {63'd0, WE3}, 64'd1);
      chk("p0_a3", {59'd0, A3}, 64'd1);
      chk("p0_last_gnt", {63'd0, last_gnt}, 64'd0);
      tick();
      chk("p0_x1", {32'd0, rf[1]}, 64'hAAAA_BBBB);

      // Port 1 writes x0: consumed, never issued
      req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'hFFFF_FFFF;
      #1;
      chk("x0_rdy1", {63'd0, req1_ready}, 64'd1);
      tick();
      req1_valid = 1'b0;
      chk("x0_we3", {63'd0, WE3}, 64'd0);
      chk("x0_last_gnt", {63'd0, last_gnt}, 64'd1);
      tick();
      chk("x0_val", {32'd0, rf[0]}, 64'd0);

      // Clear request while port 0 holds a request
      req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'h5555_6666;
      clr_req = 1'b1;
      #1;
      chk("clr_rdy0", {63'd0, req0_ready}, 64'd0);
      chk("clr_rdy1", {63'd0, req1_ready}, 64'd0);
      push_sweep(31);
      tick();
      clr_req = 1'b0;
      chk("clr_we3", {63'd0, WE3}, 64'd0);
      chk("clr_busy", {63'd0, busy}, 64'd1);
      do_sweep();
      exp_q.push_back({5'd5, 32'h5555_6666});
      tick();
      req0_valid = 1'b0;
      chk("clr_pend_we3", {63'd0, WE3}, 64'd1);
      tick();
      for (int i = 1; i < 32; i++)
         chk("clr_reg", {32'd0, rf[i]}, (i == 5) ? 64'h5555_6666 : 64'd0);

      // Reset in the middle of a sweep, at step A3=10
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      push_sweep(10);
      for (int i = 0; i < 10; i++) tick();
      chk("mid_a3", {59'd0, A3}, 64'd10);
      rst = 1'b1;
      tick();
      chk("mid_rst_we3", {63'd0, WE3}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd1);
      rst = 1'b0;
      push_sweep(31);
      do_sweep();
      tick();

      // Same destination on both ports: later grant wins
      req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h7000_0000;
      req1_valid = 1'b1; req1_rd = 5'd7; req1_data = 32'h7111_1111;
      #1;
      chk("same_rdy0", {63'd0, req0_ready}, 64'd1);
      chk("same_rdy1", {63'd0, req1_ready}, 64'd0);
      exp_q.push_back({5'd7, 32'h7000_0000});
      tick();
      req0_valid = 1'b0;
      #1;
      chk("same_rdy1b", {63'd0, req1_ready}, 64'd1);
      exp_q.push_back({5'd7, 32'h7111_1111});
      tick();
      req1_valid = 1'b0;
      tick(); tick();
      chk("same_x7", {32'd0, rf[7]}, 64'h7111_1111);

      tick();
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
